// File: rtl/mac_pkg.sv
// Shared constants and types for the (G)MII receive MAC: FSM encoding,
// pointer-word layout, Ethernet CRC constants and frame length limits.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREA,
    ST_DATA,
    ST_FLSH,
    ST_DROP
  } rx_state_e;

  localparam logic [15:0] DEF_TTE_ETYPE = 16'h891D;
  localparam int          DEF_MAX_LEN   = 1536;
  localparam int          DEF_MIN_LEN   = 64;
  localparam int          DEF_MAX_LEGAL = 1522;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam int DL_DEPTH      = 14;
  localparam int FCS_BYTES     = 4;
  localparam int FLUSH_BYTES   = DL_DEPTH - FCS_BYTES;
  localparam int MIN_FLUSH_LEN = 18;

  localparam int PTR_GIG     = 11;
  localparam int PTR_CRC_ERR = 12;
  localparam int PTR_RX_ERR  = 13;
  localparam int PTR_LEN_ERR = 14;

  function automatic logic [15:0] make_ptr(input logic [10:0] len, input logic gig,
                                           input logic crc_err, input logic rx_err,
                                           input logic len_err);
    logic [15:0] p;
    p              = '0;
    p[10:0]        = len;
    p[PTR_GIG]     = gig;
    p[PTR_CRC_ERR] = crc_err;
    p[PTR_RX_ERR]  = rx_err;
    p[PTR_LEN_ERR] = len_err;
    return p;
  endfunction

endpackage

// File: rtl/crc32_8023.sv
// IEEE 802.3 CRC-32, one byte per enable, bits consumed LSB first into an
// MSB-first register; a frame with its FCS leaves CRC_RESIDUE behind.
module crc32_8023
  import mac_pkg::*;
(
  input  logic        rx_clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_n;
  logic        fb;

  always_comb begin
    crc_n = crc;
    fb    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb    = crc_n[31] ^ d[i];
      crc_n = {crc_n[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn)     crc <= '0;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_n;
  end

endmodule

// File: rtl/mac_r_gmii_tte_rx.sv
// (G)MII receive MAC: byte assembly, preamble strip, 14-byte delay line for
// TTE/normal classification, FCS/length checks and FIFO pointer generation.
//
// state | meaning
// IDLE  | line quiet, waiting for rx_dv
// PREA  | inside preamble, hunting for SFD
// DATA  | counting post-SFD bytes; writing once admitted at byte 14
// FLSH  | draining 10 payload bytes from the delay line, then pointer word
// DROP  | frame rejected or ignored; wait for rx_dv to fall
module mac_r_gmii_tte_rx
  import mac_pkg::*;
#(
  parameter logic [15:0] TTE_ETYPE = DEF_TTE_ETYPE,
  parameter int          MAX_LEN   = DEF_MAX_LEN,
  parameter int          MIN_LEN   = DEF_MIN_LEN,
  parameter int          MAX_LEGAL = DEF_MAX_LEGAL
) (
  input  logic        rx_clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_d,
  input  logic [1:0]  speed,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_dout,
  input  logic        data_fifo_bp,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_full,
  output logic        tdata_fifo_wr,
  output logic [7:0]  tdata_fifo_dout,
  input  logic        tdata_fifo_bp,
  output logic        tptr_fifo_wr,
  output logic [15:0] tptr_fifo_dout,
  input  logic        tptr_fifo_full,
  output logic        rx_drop_pulse,
  output logic        rx_crc_err_pulse
);

  rx_state_e   state, state_n;
  logic        dv_q, gmii_q, phase_q, gig_q, tte_q, er_q, ign_q;
  logic [3:0]  nib_q, fl_cnt;
  logic [10:0] cnt;
  logic [7:0]  dl [DL_DEPTH];
  logic [31:0] crc;
  logic [7:0]  dout_q;
  logic [15:0] ptr_q;

  logic        gmii, byte_vld, cls_tte, crc_bad, len_err;
  logic [7:0]  byte_val;
  logic [15:0] ptr_word;
  logic        take, sfd, wr_byte, wr_ptr, drop;
  logic        unused_speed0;

  assign unused_speed0 = speed[0];

  // Mode is frozen at the rx_dv rising edge; MII pairs nibbles low-first.
  assign gmii     = (rx_dv && !dv_q) ? speed[1] : gmii_q;
  assign byte_vld = rx_dv && (gmii || phase_q);
  assign byte_val = gmii ? rx_d : {rx_d[3:0], nib_q};

  assign cls_tte  = ({dl[0], byte_val} == TTE_ETYPE);
  assign crc_bad  = (crc != CRC_RESIDUE);
  assign len_err  = (cnt < 11'(MIN_LEN)) || (cnt > 11'(MAX_LEGAL));
  assign ptr_word = make_ptr(cnt - 11'(FCS_BYTES), gig_q, crc_bad, er_q, len_err);

  always_comb begin
    state_n = state;
    take    = 1'b0;
    sfd     = 1'b0;
    wr_byte = 1'b0;
    wr_ptr  = 1'b0;
    drop    = 1'b0;
    unique case (state)
      ST_IDLE: if (rx_dv) state_n = ST_PREA;
      ST_PREA: begin
        if (!rx_dv) state_n = ST_IDLE;
        else if (byte_vld) begin
          if (byte_val == SFD_BYTE) begin
            state_n = ST_DATA;
            sfd     = 1'b1;
          end else if (byte_val != PRE_BYTE) begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (!rx_dv) begin
          if (cnt < 11'(MIN_FLUSH_LEN)) begin
            state_n = ST_IDLE;
            drop    = 1'b1;
          end else begin
            state_n = ST_FLSH;
          end
        end else if (byte_vld && (cnt < 11'(MAX_LEN))) begin
          take = 1'b1;
          if (cnt == 11'(DL_DEPTH - 1)) begin
            if (cls_tte ? (tdata_fifo_bp || tptr_fifo_full)
                        : (data_fifo_bp || ptr_fifo_full)) begin
              state_n = ST_DROP;
              drop    = 1'b1;
            end
          end else if (cnt >= 11'(DL_DEPTH)) begin
            wr_byte = 1'b1;
          end
        end
      end
      ST_FLSH: begin
        // A frame starting during the flush is ignored with a single pulse.
        drop = rx_dv && !ign_q;
        if (fl_cnt < 4'(FLUSH_BYTES)) begin
          wr_byte = 1'b1;
        end else begin
          wr_ptr  = 1'b1;
          state_n = (rx_dv || ign_q) ? ST_DROP : ST_IDLE;
        end
      end
      ST_DROP: if (!rx_dv) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      dv_q    <= 1'b0;
      gmii_q  <= 1'b0;
      phase_q <= 1'b0;
      nib_q   <= '0;
      gig_q   <= 1'b0;
      tte_q   <= 1'b0;
      er_q    <= 1'b0;
      ign_q   <= 1'b0;
      fl_cnt  <= '0;
      cnt     <= '0;
      for (int i = 0; i < DL_DEPTH; i++) dl[i] <= '0;
    end else begin
      state <= state_n;
      dv_q  <= rx_dv;
      if (rx_dv && !dv_q) gmii_q <= speed[1];
      if (!rx_dv) begin
        phase_q <= 1'b0;
      end else if (!gmii) begin
        phase_q <= !phase_q;
        if (!phase_q) nib_q <= rx_d[3:0];
      end
      if (sfd) begin
        cnt    <= '0;
        gig_q  <= gmii_q;
        er_q   <= 1'b0;
        ign_q  <= 1'b0;
        fl_cnt <= '0;
      end
      if (state == ST_DATA && ((rx_dv && rx_er) || (!rx_dv && phase_q))) er_q <= 1'b1;
      if (take) begin
        cnt <= cnt + 11'd1;
        if (cnt == 11'(DL_DEPTH - 1)) tte_q <= cls_tte;
      end
      if (take || state == ST_FLSH) begin
        dl[0] <= take ? byte_val : 8'h00;
        for (int i = 1; i < DL_DEPTH; i++) dl[i] <= dl[i-1];
      end
      if (state == ST_FLSH) begin
        fl_cnt <= fl_cnt + 4'd1;
        if (rx_dv) ign_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      data_fifo_wr     <= 1'b0;
      tdata_fifo_wr    <= 1'b0;
      ptr_fifo_wr      <= 1'b0;
      tptr_fifo_wr     <= 1'b0;
      dout_q           <= '0;
      ptr_q            <= '0;
      rx_drop_pulse    <= 1'b0;
      rx_crc_err_pulse <= 1'b0;
    end else begin
      data_fifo_wr     <= wr_byte && !tte_q;
      tdata_fifo_wr    <= wr_byte && tte_q;
      ptr_fifo_wr      <= wr_ptr && !tte_q;
      tptr_fifo_wr     <= wr_ptr && tte_q;
      if (wr_byte) dout_q <= dl[DL_DEPTH-1];
      if (wr_ptr)  ptr_q  <= ptr_word;
      rx_drop_pulse    <= drop;
      rx_crc_err_pulse <= wr_ptr && crc_bad;
    end
  end

  assign data_fifo_dout  = dout_q;
  assign tdata_fifo_dout = dout_q;
  assign ptr_fifo_dout   = ptr_q;
  assign tptr_fifo_dout  = ptr_q;

  crc32_8023 u_crc (
    .rx_clk (rx_clk),
    .rstn   (rstn),
    .init   (sfd),
    .en     (take),
    .d      (byte_val),
    .crc    (crc)
  );

endmodule

// File: tb/tb_mac_r_gmii_tte_rx.sv
// Bench for mac_r_gmii_tte_rx: directed and random frames checked against a
// frame-level model using a reflected (table-free) Ethernet FCS computation.
module tb_mac_r_gmii_tte_rx;

  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;

  logic       rx_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;
  logic [7:0] rx_d = 8'h00;
  logic [1:0] speed = 2'b00;
  logic       data_fifo_bp = 1'b0, ptr_fifo_full = 1'b0;
  logic       tdata_fifo_bp = 1'b0, tptr_fifo_full = 1'b0;
  logic       data_fifo_wr, ptr_fifo_wr, tdata_fifo_wr, tptr_fifo_wr;
  logic [7:0] data_fifo_dout, tdata_fifo_dout;
  logic [15:0] ptr_fifo_dout, tptr_fifo_dout;
  logic       rx_drop_pulse, rx_crc_err_pulse;

  int checks = 0, passed = 0;

  u8  cap_d[$], cap_t[$];
  u16 cap_p[$], cap_tp[$];
  int n_drop = 0, n_crcp = 0, n_coinc = 0;

  u8  exp_dn[$], exp_dt[$];
  u16 exp_pn[$], exp_pt[$];
  int exp_drop, exp_crcp;

  always #4 rx_clk = ~rx_clk;

  mac_r_gmii_tte_rx dut (
    .rx_clk(rx_clk), .rstn(rstn), .rx_dv(rx_dv), .rx_er(rx_er), .rx_d(rx_d), .speed(speed),
    .data_fifo_wr(data_fifo_wr), .data_fifo_dout(data_fifo_dout), .data_fifo_bp(data_fifo_bp),
    .ptr_fifo_wr(ptr_fifo_wr), .ptr_fifo_dout(ptr_fifo_dout), .ptr_fifo_full(ptr_fifo_full),
    .tdata_fifo_wr(tdata_fifo_wr), .tdata_fifo_dout(tdata_fifo_dout), .tdata_fifo_bp(tdata_fifo_bp),
    .tptr_fifo_wr(tptr_fifo_wr), .tptr_fifo_dout(tptr_fifo_dout), .tptr_fifo_full(tptr_fifo_full),
    .rx_drop_pulse(rx_drop_pulse), .rx_crc_err_pulse(rx_crc_err_pulse)
  );

  always @(negedge rx_clk) begin
    if (data_fifo_wr)  cap_d.push_back(data_fifo_dout);
    if (tdata_fifo_wr) cap_t.push_back(tdata_fifo_dout);
    if (ptr_fifo_wr)   cap_p.push_back(ptr_fifo_dout);
    if (tptr_fifo_wr)  cap_tp.push_back(tptr_fifo_dout);
    if (rx_drop_pulse)    n_drop++;
    if (rx_crc_err_pulse) n_crcp++;
    if ((data_fifo_wr || tdata_fifo_wr) && (ptr_fifo_wr || tptr_fifo_wr)) n_coinc++;
  end

  function automatic logic [31:0] eth_fcs(input u8 q[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int q8_diff(input u8 a[$], input u8 b[$]);
    int m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : m;
  endfunction

  function automatic int q16_diff(input u16 a[$], input u16 b[$]);
    int m = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : m;
  endfunction

  task automatic make_frame(input int n, input logic [15:0] et, output u8 q[$]);
    logic [31:0] f;
    q = {};
    for (int i = 0; i < n - 4; i++) q.push_back(u8'($urandom));
    q[12] = et[15:8];
    q[13] = et[7:0];
    f = eth_fcs(q, n - 4);
    q.push_back(f[7:0]); q.push_back(f[15:8]); q.push_back(f[23:16]); q.push_back(f[31:24]);
  endtask

  // Frame-level expectation: admission at byte 14, FCS stripped, truncation at 1536.
  task automatic predict(input u8 q[$], input bit gig, input bit er, input bit blk_n, input bit blk_t);
    int n, keep;
    bit tte, crcbad, lenerr;
    logic [31:0] f;
    u16 p;
    exp_dn = {}; exp_dt = {}; exp_pn = {}; exp_pt = {};
    exp_drop = 0; exp_crcp = 0;
    n = q.size();
    if (n < 14) begin exp_drop = 1; return; end
    tte = ({q[12], q[13]} == 16'h891D);
    if (tte ? blk_t : blk_n) begin exp_drop = 1; return; end
    keep = (n > 1536) ? 1536 : n;
    if (keep < 18) begin
      for (int i = 0; i < keep - 14; i++) if (tte) exp_dt.push_back(q[i]); else exp_dn.push_back(q[i]);
      exp_drop = 1;
      return;
    end
    for (int i = 0; i < keep - 4; i++) if (tte) exp_dt.push_back(q[i]); else exp_dn.push_back(q[i]);
    f = eth_fcs(q, keep - 4);
    crcbad = (f != {q[keep-1], q[keep-2], q[keep-3], q[keep-4]});
    lenerr = (n < 64) || (n > 1522);
    p = {1'b0, lenerr, er, crcbad, gig, 11'(keep - 4)};
    if (tte) exp_pt.push_back(p); else exp_pn.push_back(p);
    exp_crcp = crcbad;
  endtask

  task automatic clear_caps();
    cap_d = {}; cap_t = {}; cap_p = {}; cap_tp = {};
    n_drop = 0; n_crcp = 0; n_coinc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic drive_byte(input u8 b, input bit gig, input bit er);
    rx_dv = 1'b1;
    rx_er = er;
    if (gig) begin
      rx_d = b; @(negedge rx_clk);
    end else begin
      rx_d = {4'h0, b[3:0]}; @(negedge rx_clk);
      rx_d = {4'h0, b[7:4]}; @(negedge rx_clk);
    end
  endtask

  task automatic send_frame(input u8 q[$], input bit gig, input int er_idx, input bit odd, input int rst_at);
    @(negedge rx_clk);
    speed = gig ? 2'b10 : 2'b01;
    for (int i = 0; i < 8; i++) drive_byte((i == 7) ? 8'hD5 : 8'h55, gig, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (i == rst_at) begin
        rstn = 1'b0;
        break;
      end
      drive_byte(q[i], gig, i == er_idx);
    end
    if (odd && !gig && rst_at < 0) begin
      rx_dv = 1'b1; rx_er = 1'b0; rx_d = 8'h0A;
      @(negedge rx_clk);
    end
    rx_dv = 1'b0; rx_er = 1'b0; rx_d = 8'h00;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(3);
    checks++;
    if ({data_fifo_wr, ptr_fifo_wr, tdata_fifo_wr, tptr_fifo_wr, rx_drop_pulse, rx_crc_err_pulse,
         data_fifo_dout, tdata_fifo_dout, ptr_fifo_dout, tptr_fifo_dout} !== 54'h0)
      $display("FAIL reset_outputs: outputs not all zero during reset");
    else passed++;
    rstn = 1'b1;
    idle(3);
  endtask

  task automatic test_gmii_normal();
    u8 q[$];
    make_frame(64, 16'h0800, q);
    predict(q, 1, 0, 0, 0);
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (cap_d.size() !== 60) $display("FAIL gmii_normal_count: got %0d writes, want 60", cap_d.size());
    else passed++;
    checks++;
    if (q8_diff(cap_d, exp_dn) != -1) $display("FAIL gmii_normal_data: first diff at byte %0d", q8_diff(cap_d, exp_dn));
    else passed++;
    checks++;
    if ((cap_p.size() == 1 ? cap_p[0] : 16'hFFFF) !== 16'h083C)
      $display("FAIL gmii_normal_ptr: got %0d ptrs first %h, want one 083c", cap_p.size(), cap_p.size() ? cap_p[0] : 16'hFFFF);
    else passed++;
    checks++;
    if (n_crcp + cap_t.size() + cap_tp.size() !== 0) $display("FAIL gmii_normal_side: crc pulses %0d, tte writes %0d", n_crcp, cap_t.size());
    else passed++;
  endtask

  task automatic test_mii_tte();
    u8 q[$];
    make_frame(100, 16'h891D, q);
    predict(q, 0, 0, 0, 0);
    clear_caps();
    send_frame(q, 0, -1, 0, -1);
    idle(25);
    checks++;
    if (q8_diff(cap_t, exp_dt) != -1 || cap_t.size() !== 96)
      $display("FAIL mii_tte_data: got %0d bytes, want 96, first diff %0d", cap_t.size(), q8_diff(cap_t, exp_dt));
    else passed++;
    checks++;
    if ((cap_tp.size() == 1 ? cap_tp[0] : 16'hFFFF) !== 16'h0060)
      $display("FAIL mii_tte_ptr: got %0d ptrs, first %h, want one 0060", cap_tp.size(), cap_tp.size() ? cap_tp[0] : 16'hFFFF);
    else passed++;
    checks++;
    if (cap_d.size() + cap_p.size() !== 0) $display("FAIL mii_tte_normal: got %0d normal writes, want 0", cap_d.size() + cap_p.size());
    else passed++;
  endtask

  task automatic test_crc_err();
    u8 q[$];
    make_frame(64, 16'h0800, q);
    q[30] = q[30] ^ 8'h40;
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if ((cap_p.size() == 1 ? cap_p[0] : 16'hFFFF) !== 16'h183C)
      $display("FAIL crc_err_ptr: got %h, want 183c", cap_p.size() ? cap_p[0] : 16'hFFFF);
    else passed++;
    checks++;
    if (n_crcp !== 1) $display("FAIL crc_err_pulse: got %0d pulses, want 1", n_crcp);
    else passed++;
  endtask

  task automatic test_backpressure();
    u8 q[$];
    make_frame(80, 16'h0800, q);
    clear_caps();
    data_fifo_bp = 1'b1;
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    data_fifo_bp = 1'b0;
    checks++;
    if (cap_d.size() + cap_p.size() + cap_t.size() + cap_tp.size() !== 0 || n_drop !== 1)
      $display("FAIL bp_drop: got %0d writes %0d drops, want 0 and 1", cap_d.size() + cap_p.size(), n_drop);
    else passed++;
    make_frame(72, 16'h0800, q);
    predict(q, 1, 0, 0, 0);
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (q16_diff(cap_p, exp_pn) != -1 || q8_diff(cap_d, exp_dn) != -1 || n_drop !== 0)
      $display("FAIL bp_recover: got %0d ptrs %0d bytes %0d drops, want 1 ptr %0d bytes 0 drops", cap_p.size(), cap_d.size(), n_drop, exp_dn.size());
    else passed++;
  endtask

  task automatic test_truncation();
    u8 q[$];
    make_frame(1600, 16'h0800, q);
    predict(q, 1, 0, 0, 0);
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (cap_d.size() !== 1532 || q8_diff(cap_d, exp_dn) != -1)
      $display("FAIL trunc_data: got %0d bytes, want 1532, first diff %0d", cap_d.size(), q8_diff(cap_d, exp_dn));
    else passed++;
    checks++;
    if ((cap_p.size() == 1 ? cap_p[0] : 16'hFFFF) !== 16'h5DFC)
      $display("FAIL trunc_ptr: got %h, want 5dfc", cap_p.size() ? cap_p[0] : 16'hFFFF);
    else passed++;
  endtask

  task automatic test_odd_nibble();
    u8 q[$];
    make_frame(80, 16'h0800, q);
    clear_caps();
    send_frame(q, 0, -1, 1, -1);
    idle(25);
    checks++;
    if ((cap_p.size() == 1 ? cap_p[0] : 16'hFFFF) !== 16'h204C)
      $display("FAIL odd_nibble_ptr: got %h, want 204c", cap_p.size() ? cap_p[0] : 16'hFFFF);
    else passed++;
  endtask

  task automatic test_short_and_midreset();
    u8 q[$];
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(u8'($urandom));
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (cap_p.size() + cap_tp.size() !== 0 || n_drop !== 1)
      $display("FAIL short_frame: got %0d ptrs %0d drops, want 0 and 1", cap_p.size() + cap_tp.size(), n_drop);
    else passed++;
    make_frame(100, 16'h891D, q);
    clear_caps();
    send_frame(q, 1, -1, 0, 40);
    @(negedge rx_clk);
    checks++;
    if ({data_fifo_wr, ptr_fifo_wr, tdata_fifo_wr, tptr_fifo_wr, rx_drop_pulse, rx_crc_err_pulse,
         data_fifo_dout, ptr_fifo_dout} !== 30'h0)
      $display("FAIL midreset_outputs: outputs not zero under reset");
    else passed++;
    idle(3);
    rstn = 1'b1;
    idle(25);
    checks++;
    if (cap_p.size() + cap_tp.size() !== 0) $display("FAIL midreset_ptr: got %0d pointer writes, want 0", cap_p.size() + cap_tp.size());
    else passed++;
    make_frame(64, 16'h891D, q);
    predict(q, 1, 0, 0, 0);
    clear_caps();
    send_frame(q, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (q16_diff(cap_tp, exp_pt) != -1 || q8_diff(cap_t, exp_dt) != -1)
      $display("FAIL midreset_recover: got %0d ptrs %0d bytes, want %0d and %0d", cap_tp.size(), cap_t.size(), exp_pt.size(), exp_dt.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    u8 qa[$], qb[$];
    make_frame(70, 16'h0800, qa);
    make_frame(64, 16'h0800, qb);
    predict(qa, 1, 0, 0, 0);
    clear_caps();
    send_frame(qa, 1, -1, 0, -1);
    send_frame(qb, 1, -1, 0, -1);
    idle(25);
    checks++;
    if (q16_diff(cap_p, exp_pn) != -1 || q8_diff(cap_d, exp_dn) != -1)
      $display("FAIL b2b_first: got %0d ptrs %0d bytes, want %0d and %0d", cap_p.size(), cap_d.size(), exp_pn.size(), exp_dn.size());
    else passed++;
    checks++;
    if (n_drop !== 1 || n_coinc !== 0) $display("FAIL b2b_drop: got %0d drops %0d overlaps, want 1 and 0", n_drop, n_coinc);
    else passed++;
  endtask

  task automatic test_random();
    u8 q[$];
    int n, er_idx, idx;
    bit gig, tte, odd, bn, bt, fn, ft;
    for (int f = 0; f < 12; f++) begin
      n   = $urandom_range(40, 180);
      gig = $urandom_range(0, 1);
      tte = $urandom_range(0, 1);
      make_frame(n, tte ? 16'h891D : 16'h0800, q);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(14, n - 5);
        q[idx] = q[idx] ^ 8'h10;
      end
      er_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      odd = !gig && ($urandom_range(0, 4) == 0);
      bn = ($urandom_range(0, 5) == 0); fn = ($urandom_range(0, 7) == 0);
      bt = ($urandom_range(0, 5) == 0); ft = ($urandom_range(0, 7) == 0);
      predict(q, gig, (er_idx >= 0) || odd, bn || fn, bt || ft);
      clear_caps();
      data_fifo_bp = bn; ptr_fifo_full = fn; tdata_fifo_bp = bt; tptr_fifo_full = ft;
      send_frame(q, gig, er_idx, odd, -1);
      idle(25);
      data_fifo_bp = 1'b0; ptr_fifo_full = 1'b0; tdata_fifo_bp = 1'b0; tptr_fifo_full = 1'b0;
      checks++;
      if (q8_diff(cap_d, exp_dn) != -1 || q8_diff(cap_t, exp_dt) != -1)
        $display("FAIL rand%0d_data: got %0d/%0d bytes, want %0d/%0d", f, cap_d.size(), cap_t.size(), exp_dn.size(), exp_dt.size());
      else passed++;
      checks++;
      if (q16_diff(cap_p, exp_pn) != -1 || q16_diff(cap_tp, exp_pt) != -1)
        $display("FAIL rand%0d_ptr: got %h/%h, want %h/%h", f, cap_p.size() ? cap_p[0] : 16'hFFFF, cap_tp.size() ? cap_tp[0] : 16'hFFFF,
                 exp_pn.size() ? exp_pn[0] : 16'hFFFF, exp_pt.size() ? exp_pt[0] : 16'hFFFF);
      else passed++;
      checks++;
      if (n_drop !== exp_drop || n_crcp !== exp_crcp || n_coinc !== 0)
        $display("FAIL rand%0d_pulses: got drop %0d crc %0d overlap %0d, want %0d %0d 0", f, n_drop, n_crcp, n_coinc, exp_drop, exp_crcp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_gmii_normal();
    test_mii_tte();
    test_crc_err();
    test_backpressure();
    test_truncation();
    test_odd_nibble();
    test_short_and_midreset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
